// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: access width codes,
// FSM state encoding, read-latency bounds and the byte-lane mask helper.
package dmem_resp_pkg;

  localparam logic [1:0] DM_BYTE     = 2'b00;
  localparam logic [1:0] DM_HALFWORD = 2'b01;
  localparam logic [1:0] DM_WORD     = 2'b10;

  localparam int RD_LAT_MAX = 3;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte enables a well-formed access of this width/offset must carry.
  function automatic logic [3:0] lane_mask(input logic [1:0] width,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    case (width)
      DM_BYTE:     mask = 4'b0001 << offset;
      DM_HALFWORD: mask = 4'b0011 << offset;
      DM_WORD:     mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory responder: store data shifted onto
// its lanes, load data right-justified, and a shared misalignment detect.
module dmem_lane_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  offset_i,
  input  logic [3:0]  dwea_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] st_lane_o,
  output logic [31:0] ld_just_o,
  output logic        ld_mis_o,
  output logic        st_mis_o
);

  logic addr_mis;

  always_comb begin
    addr_mis = 1'b0;
    case (width_i)
      DM_BYTE:     addr_mis = 1'b0;
      DM_HALFWORD: addr_mis = offset_i[0];
      DM_WORD:     addr_mis = |offset_i;
      default:     addr_mis = 1'b1;
    endcase
  end

  assign ld_mis_o = addr_mis;
  // A store whose enables disagree with width/offset is rejected like a misaligned one.
  assign st_mis_o = addr_mis | (dwea_i != lane_mask(width_i, offset_i));

  assign st_lane_o = st_data_i << {offset_i, 3'b000};
  assign ld_just_o = ld_data_i >> {offset_i, 3'b000};

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: drives a synchronous single-port SRAM for pipeline
// loads/stores, stalling the pipeline while a read is in flight.
//
// state | meaning
// IDLE  | accept a store (same cycle) or issue an aligned load read
// WAIT  | read in flight, count down RD_LAT-1..0, capture on zero
// RESP  | Data_in valid, pipeline advances, return to IDLE
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_w,
  input  logic                  mem_r,
  input  logic [1:0]            mem_width,
  input  logic [3:0]            DWea,
  input  logic [ADDR_W-1:0]     Addr_out,
  input  logic [31:0]           Data_out,
  output logic [31:0]           Data_in,
  output logic                  stall,
  output logic                  err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0] st_lane, ld_just;
  logic        ld_mis, st_mis;
  logic        unused_addr;

  dmem_lane_align u_align (
    .width_i   (mem_width),
    .offset_i  (Addr_out[1:0]),
    .dwea_i    (DWea),
    .st_data_i (Data_out),
    .ld_data_i (sram_rdata),
    .st_lane_o (st_lane),
    .ld_just_o (ld_just),
    .ld_mis_o  (ld_mis),
    .st_mis_o  (st_mis)
  );

  // Addresses wrap at the SRAM size; the upper bits are deliberately dropped.
  assign unused_addr = ^Addr_out[ADDR_W-1:DEPTH_LOG2+2];
  assign sram_addr   = Addr_out[DEPTH_LOG2+1:2];
  assign sram_wdata  = st_lane;
  assign Data_in     = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    sram_en = 1'b0;
    sram_we = 4'b0000;
    stall   = 1'b0;
    err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_w) begin
          sram_en = ~st_mis;
          sram_we = st_mis ? 4'b0000 : DWea;
          err     = st_mis | mem_r;
        end else if (mem_r) begin
          if (ld_mis) begin
            err     = 1'b1;
            rdata_d = '0;
          end else begin
            sram_en = 1'b1;
            stall   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          rdata_d = ld_just;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // mem_r here is still the load being completed, so only stores count.
        state_d = IDLE;
        if (mem_w) begin
          sram_en = ~st_mis;
          sram_we = st_mis ? 4'b0000 : DWea;
          err     = st_mis;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      sram_en = 1'b0;
      sram_we = 4'b0000;
      stall   = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
